// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: owns the PC, reads program memory, hands words to decode
// Async-read memory: address and rd are driven in FETCH, the word is captured at the end of that cycle.
module instruction_fetch #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [DWIDTH-1:0] instr_out,
  output logic [AWIDTH-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [AWIDTH-1:0] jump_addr,
  input  logic              halt,
  output logic              halted
);

  typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_VALID, ST_HALTED} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] ipc_q;
  logic [DWIDTH-1:0] instr_q;
  logic              capture;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      pc_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (capture) begin
        instr_q <= mem_rdata;
        ipc_q   <= pc_q;
      end
    end
  end

  // Jump outranks halt everywhere; a held instruction is only released by handshake or jump.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        if (jump_en) begin
          pc_d = jump_addr;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else begin
          capture = 1'b1;
          pc_d    = pc_q + AWIDTH'(1);
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (jump_en) begin
          pc_d    = jump_addr;
          state_d = ST_FETCH;
        end else if (instr_ready) begin
          state_d = halt ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: begin
        if (jump_en) pc_d = jump_addr;
        if (!halt) state_d = ST_FETCH;
      end
      default: state_d = ST_RST;
    endcase
  end

  assign mem_rd      = (state_q == ST_FETCH);
  assign mem_addr    = (state_q == ST_RST) ? '0 : pc_q;
  assign mem_wr      = 1'b0;
  assign mem_wdata   = '0;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = (state_q == ST_VALID);
  assign halted      = (state_q == ST_HALTED);

endmodule
